output_unpack_reg: RTL and testbench
====================================

Name: output_unpack_reg

Overview:
- Return-path block for the input lane sorter.
- Accepts the 32-bit lane-replicated beats that the sorter produces for the 2-, 4- and 8-bit weight modes and reconstructs the original packed 32-bit buffer words.
- Sits between the fusion-array result/readback path and the buffer write port.
- Uses a valid/ready handshake on both sides, a one-entry output register, and sticky error flags for replication mismatches and reserved modes.

Parameters:
- CHECK_DUP, 1, 1 = compare all replicated copies and flag mismatches; 0 = use only the low copy and never set err_dup.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- weight_bitwidth  input  2  00 = 8-bit, 01 = 4-bit, 10 = 2-bit, 11 = reserved.
- in_valid  input  1  beat present on in_data.
- in_ready  output  1  block can accept a beat.
- in_data  input  32  sorted/replicated beat.
- out_valid  output  1  packed word available.
- out_ready  input  1  downstream accepts out_data.
- out_data  output  32  reconstructed packed word.
- clr_err  input  1  synchronous clear of the sticky error flags.
- err_dup  output  1  sticky: replicated copies disagreed.
- err_mode  output  1  sticky: beat accepted while mode = 11.

Behaviour:
- Reset (reset low, asynchronous) forces: out_valid=0, out_data=0, err_dup=0, err_mode=0, beat counter=0, accumulator=0, latched mode=00.
- Handshake:
  - in_ready = !out_valid | out_ready (combinational).
  - A beat is accepted when in_valid & in_ready.
  - An output is consumed when out_valid & out_ready.
- Mode latching:
  - weight_bitwidth is sampled on the first accepted beat of a word (beat counter = 0) and held until that word completes.
  - Changes mid-word are ignored.
- Beats per word: 1 (00), 2 (01), 4 (10). The beat counter wraps to 0 after the last beat.
- 8-bit: word = in_data.
- 4-bit, beat j (j = 0 fills word[15:0], j = 1 fills word[31:16]); with base = 16j:
  - in[1:0] → base+1:0
  - in[5:4] → base+5:4
  - in[9:8] → base+3:2
  - in[13:12] → base+7:6
  - in[17:16] → base+9:8
  - in[21:20] → base+13:12
  - in[25:24] → base+11:10
  - in[29:28] → base+15:14
- 2-bit, beat k fills word byte k:
  - in[1:0] → bits 8k+1:8k
  - in[9:8] → bits 8k+3:8k+2
  - in[17:16] → bits 8k+5:8k+4
  - in[25:24] → bits 8k+7:8k+6
- Accumulation: partial words accumulate in an internal register. Bits not yet written in the current word read as 0.
- Completion: on acceptance of the final beat, out_data ← assembled word and out_valid ← 1 on the next edge, so latency is 1 cycle after the last beat.
- out_valid clears on consumption unless a new word completes in the same cycle.
- Throughput: 8-bit mode sustains one word per cycle while out_ready is high.
- Back-pressure: out_data is stable while out_valid & !out_ready, and in_ready is low during this time.
- Duplication check (CHECK_DUP=1, on accepted beats only):
  - 4-bit: each nibble's two 2-bit copies must be equal.
  - 2-bit: each byte's four 2-bit copies must be equal.
  - Any mismatch sets err_dup. Data is still taken from the low copy.
- Mode 11 beat:
  - Accepted (in_ready rule unchanged) and dropped; sets err_mode.
  - Beat counter and accumulator are unchanged.
  - No output is produced.
- clr_err: clears both flags next edge. If an error event occurs in the same cycle, the set wins.
- Reset mid-word: the partial word is discarded and no output is produced.

Test Plan:
- 8-bit, in_data=0xDEADBEEF, out_ready=1 → out_data=0xDEADBEEF, out_valid high exactly 1 cycle after acceptance; back-to-back beats 0x1, 0x2 produce outputs on consecutive cycles.
- 4-bit, beats 0x005A05F0 then 0x00000000 → out_data=0x00001234 one cycle after beat 2; err_dup=0.
- 2-bit, beats 0x5500FFAA, 0x00000000, 0x00000000, 0x00000000 → out_data=0x0000004E after beat 4.
- Switch weight_bitwidth 01→00 after the first 4-bit beat → second beat still treated as 4-bit; the next word uses 8-bit.
- Hold out_ready=0 with out_valid=1 → in_ready=0, out_data frozen 5 cycles; release → in_ready=1 same cycle.
- 2-bit beat 0x00000001 → err_dup=1 and sticky; clr_err pulse → 0. Mode 11 beat → err_mode=1 and no out_valid. Reset low mid-word → outputs 0 immediately.

Source files
------------

// File: rtl/output_unpack_reg.sv
// Return-path unpacker: rebuilds packed 32-bit buffer words from the lane-replicated
// beats produced by the input lane sorter in 8/4/2-bit weight modes.
module output_unpack_reg #(
  parameter bit CHECK_DUP = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  weight_bitwidth,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  input  logic        clr_err,
  output logic        err_dup,
  output logic        err_mode
);

  typedef enum logic [1:0] {
    MODE_8B  = 2'b00,
    MODE_4B  = 2'b01,
    MODE_2B  = 2'b10,
    MODE_RSV = 2'b11
  } mode_e;

  function automatic logic [15:0] unpack_4b(input logic [31:0] d);
    logic [15:0] h;
    h        = 16'h0000;
    h[1:0]   = d[1:0];
    h[5:4]   = d[5:4];
    h[3:2]   = d[9:8];
    h[7:6]   = d[13:12];
    h[9:8]   = d[17:16];
    h[13:12] = d[21:20];
    h[11:10] = d[25:24];
    h[15:14] = d[29:28];
    return h;
  endfunction

  function automatic logic [7:0] unpack_2b(input logic [31:0] d);
    return {d[25:24], d[17:16], d[9:8], d[1:0]};
  endfunction

  function automatic logic dup_err_4b(input logic [31:0] d);
    logic e;
    e = 1'b0;
    for (int n = 0; n < 8; n++) begin
      if (d[4*n +: 2] != d[4*n+2 +: 2]) e = 1'b1;
    end
    return e;
  endfunction

  function automatic logic dup_err_2b(input logic [31:0] d);
    logic e;
    e = 1'b0;
    for (int b = 0; b < 4; b++) begin
      if ((d[8*b +: 2] != d[8*b+2 +: 2]) ||
          (d[8*b +: 2] != d[8*b+4 +: 2]) ||
          (d[8*b +: 2] != d[8*b+6 +: 2])) e = 1'b1;
    end
    return e;
  endfunction

  logic [1:0]  beat_cnt_r, beat_cnt_nx_s;
  logic [31:0] acc_r, acc_nx_s;
  mode_e       mode_r, mode_nx_s, mode_s;
  logic [31:0] out_data_r, merged_s;
  logic        out_valid_r, err_dup_r, err_mode_r;
  logic        accept_s, consume_s, word_done_s, dup_hit_s, mode_hit_s;

  assign in_ready  = ~out_valid_r | out_ready;
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign err_dup   = err_dup_r;
  assign err_mode  = err_mode_r;

  // Beat decode: effective mode, merged word, word completion and error events
  always_comb begin
    accept_s      = in_valid & in_ready;
    consume_s     = out_valid_r & out_ready;
    mode_s        = (beat_cnt_r == 2'd0) ? mode_e'(weight_bitwidth) : mode_r;
    beat_cnt_nx_s = beat_cnt_r;
    acc_nx_s      = acc_r;
    mode_nx_s     = mode_r;
    merged_s      = acc_r;
    word_done_s   = 1'b0;
    dup_hit_s     = 1'b0;
    mode_hit_s    = 1'b0;
    if (accept_s) begin
      case (mode_s)
        MODE_8B: begin
          merged_s    = in_data;
          word_done_s = 1'b1;
        end
        MODE_4B: begin
          merged_s    = acc_r | (32'(unpack_4b(in_data)) << {beat_cnt_r[0], 4'b0000});
          word_done_s = (beat_cnt_r == 2'd1);
          dup_hit_s   = CHECK_DUP & dup_err_4b(in_data);
        end
        MODE_2B: begin
          merged_s    = acc_r | (32'(unpack_2b(in_data)) << {beat_cnt_r, 3'b000});
          word_done_s = (beat_cnt_r == 2'd3);
          dup_hit_s   = CHECK_DUP & dup_err_2b(in_data);
        end
        MODE_RSV: begin
          mode_hit_s = 1'b1;
        end
        default: begin
          mode_hit_s = 1'b1;
        end
      endcase
      // Reserved-mode beats are dropped without touching the word in progress
      if (mode_s != MODE_RSV) begin
        mode_nx_s = mode_s;
        if (word_done_s) begin
          beat_cnt_nx_s = 2'd0;
          acc_nx_s      = 32'h0000_0000;
        end else begin
          beat_cnt_nx_s = beat_cnt_r + 2'd1;
          acc_nx_s      = merged_s;
        end
      end else begin
        mode_nx_s = mode_r;
      end
    end else begin
      merged_s = acc_r;
    end
  end

  // State, output register and sticky error flags
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      beat_cnt_r  <= 2'd0;
      acc_r       <= 32'h0000_0000;
      mode_r      <= MODE_8B;
      out_valid_r <= 1'b0;
      out_data_r  <= 32'h0000_0000;
      err_dup_r   <= 1'b0;
      err_mode_r  <= 1'b0;
    end else begin
      beat_cnt_r <= beat_cnt_nx_s;
      acc_r      <= acc_nx_s;
      mode_r     <= mode_nx_s;
      if (word_done_s) begin
        out_valid_r <= 1'b1;
        out_data_r  <= merged_s;
      end else if (consume_s) begin
        out_valid_r <= 1'b0;
      end else begin
        out_valid_r <= out_valid_r;
      end
      err_dup_r  <= dup_hit_s  | (err_dup_r  & ~clr_err);
      err_mode_r <= mode_hit_s | (err_mode_r & ~clr_err);
    end
  end

endmodule

// File: tb/tb_output_unpack_reg.sv
// Scoreboard bench for output_unpack_reg: expected words are queued as beats are
// driven and compared when the DUT hands a word downstream.
module tb_output_unpack_reg;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [1:0]  weight_bitwidth = 2'b00;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = 32'h0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_data;
  logic        clr_err = 1'b0;
  logic        err_dup;
  logic        err_mode;

  int checks = 0;
  int failures = 0;
  bit rnd_ready = 1'b0;
  logic [31:0] exp_q[$];

  output_unpack_reg #(.CHECK_DUP(1'b1)) dut (
    .clk(clk), .reset(reset), .weight_bitwidth(weight_bitwidth),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .clr_err(clr_err), .err_dup(err_dup), .err_mode(err_mode)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Forward (sorter-side) encoders used to build stimulus from a packed word
  function automatic logic [31:0] enc4(input logic [31:0] w, input int j);
    logic [15:0] h;
    logic [1:0]  v;
    logic [31:0] r;
    int src;
    h = w[16*j +: 16];
    r = 32'h0;
    for (int n = 0; n < 8; n++) begin
      src = 8*(n/4) + (((n%4) & 1) != 0 ? 4 : 0) + (((n%4) & 2) != 0 ? 2 : 0);
      v = h[src +: 2];
      r[4*n +: 4] = {v, v};
    end
    return r;
  endfunction

  function automatic logic [31:0] enc2(input logic [31:0] w, input int k);
    logic [7:0]  b;
    logic [1:0]  v;
    logic [31:0] r;
    b = w[8*k +: 8];
    r = 32'h0;
    for (int m = 0; m < 4; m++) begin
      v = b[2*m +: 2];
      r[8*m +: 8] = {v, v, v, v};
    end
    return r;
  endfunction

  // Called at posedge+1; returns at posedge+1 right after the accepting edge
  task automatic send_beat(input logic [1:0] m, input logic [31:0] d);
    int guard;
    guard = 0;
    weight_bitwidth = m;
    in_data = d;
    in_valid = 1'b1;
    if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
    @(negedge clk);
    while (!in_ready && guard < 200) begin
      @(posedge clk); #1;
      if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) check_eq("accept_timeout", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    check_eq("drain", 32'(exp_q.size()), 32'd0);
  endtask

  // Output monitor: a word is consumed at the next edge when valid & ready
  always @(negedge clk) begin
    if (reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) check_eq("unexpected_out", out_data, 32'hxxxx_xxxx);
      else check_eq("out_data", out_data, exp_q.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w;
    logic [1:0]  m;
    int nb;

    // Reset state
    #12;
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_out_data", out_data, 32'h0);
    check_eq("rst_err_dup", 32'(err_dup), 32'd0);
    check_eq("rst_err_mode", 32'(err_mode), 32'd0);
    check_eq("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    idle(2);

    // 8-bit: single word latency and back-to-back
    exp_q.push_back(32'hDEADBEEF);
    send_beat(2'b00, 32'hDEADBEEF);
    check_eq("lat8_valid", 32'(out_valid), 32'd1);
    exp_q.push_back(32'h1);
    exp_q.push_back(32'h2);
    send_beat(2'b00, 32'h1);
    check_eq("b2b1", out_data, 32'h1);
    send_beat(2'b00, 32'h2);
    check_eq("b2b2", out_data, 32'h2);
    check_eq("b2b2_valid", 32'(out_valid), 32'd1);
    drain();

    // 4-bit directed
    exp_q.push_back(32'h0000_1234);
    send_beat(2'b01, 32'h005A05F0);
    check_eq("4b_partial_valid", 32'(out_valid), 32'd0);
    send_beat(2'b01, 32'h0);
    check_eq("4b_valid", 32'(out_valid), 32'd1);
    check_eq("4b_err_dup", 32'(err_dup), 32'd0);
    drain();

    // 2-bit directed
    exp_q.push_back(32'h0000_004E);
    send_beat(2'b10, 32'h5500FFAA);
    send_beat(2'b10, 32'h0);
    send_beat(2'b10, 32'h0);
    check_eq("2b_partial_valid", 32'(out_valid), 32'd0);
    send_beat(2'b10, 32'h0);
    check_eq("2b_valid", 32'(out_valid), 32'd1);
    drain();

    // Mode change mid-word is ignored; next word picks up the new mode
    w = 32'hA5C3_9E17;
    exp_q.push_back(w);
    send_beat(2'b01, enc4(w, 0));
    send_beat(2'b00, enc4(w, 1));
    check_eq("switch_valid", 32'(out_valid), 32'd1);
    exp_q.push_back(32'hCAFEF00D);
    send_beat(2'b00, 32'hCAFEF00D);
    drain();

    // Back-pressure: output frozen, in_ready low, release reopens same cycle
    out_ready = 1'b0;
    exp_q.push_back(32'h1357_9BDF);
    send_beat(2'b00, 32'h1357_9BDF);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq("bp_in_ready", 32'(in_ready), 32'd0);
      check_eq("bp_out_data", out_data, 32'h1357_9BDF);
      check_eq("bp_out_valid", 32'(out_valid), 32'd1);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    #1;
    check_eq("bp_release_in_ready", 32'(in_ready), 32'd1);
    drain();

    // Random words in all valid modes with random downstream readiness
    rnd_ready = 1'b1;
    for (int t = 0; t < 40; t++) begin
      w = $urandom();
      m = 2'($urandom_range(0, 2));
      nb = (m == 2'b00) ? 1 : (m == 2'b01) ? 2 : 4;
      exp_q.push_back(w);
      for (int b = 0; b < nb; b++) begin
        send_beat((b == 0) ? m : 2'($urandom_range(0, 3)),
                  (m == 2'b00) ? w : (m == 2'b01) ? enc4(w, b) : enc2(w, b));
      end
    end
    rnd_ready = 1'b0;
    out_ready = 1'b1;
    drain();
    check_eq("rnd_err_dup", 32'(err_dup), 32'd0);
    check_eq("rnd_err_mode", 32'(err_mode), 32'd0);

    // Duplication error: sticky, cleared by clr_err, set wins over clear
    send_beat(2'b10, 32'h0000_0001);
    check_eq("dup_set", 32'(err_dup), 32'd1);
    idle(3);
    check_eq("dup_sticky", 32'(err_dup), 32'd1);
    exp_q.push_back(32'h0000_0001);
    for (int b = 0; b < 3; b++) send_beat(2'b10, 32'h0);
    drain();
    clr_err = 1'b1;
    idle(1);
    clr_err = 1'b0;
    check_eq("dup_clr", 32'(err_dup), 32'd0);
    clr_err = 1'b1;
    send_beat(2'b10, 32'h0000_0001);
    clr_err = 1'b0;
    check_eq("dup_set_wins", 32'(err_dup), 32'd1);
    exp_q.push_back(32'h0000_0001);
    for (int b = 0; b < 3; b++) send_beat(2'b10, 32'h0);
    drain();
    clr_err = 1'b1;
    idle(1);
    clr_err = 1'b0;
    check_eq("dup_clr2", 32'(err_dup), 32'd0);
    idle(2);

    // Reserved mode: dropped, flagged, counter untouched
    send_beat(2'b11, 32'hFFFF_FFFF);
    check_eq("rsv_err_mode", 32'(err_mode), 32'd1);
    check_eq("rsv_no_valid", 32'(out_valid), 32'd0);
    check_eq("rsv_no_dup", 32'(err_dup), 32'd0);
    exp_q.push_back(32'h0BAD_F00D);
    send_beat(2'b00, 32'h0BAD_F00D);
    check_eq("rsv_next_valid", 32'(out_valid), 32'd1);
    drain();

    // Reset mid-word: partial word discarded, outputs cleared immediately
    send_beat(2'b01, 32'h1234_5678);
    reset = 1'b0;
    #1;
    check_eq("mrst_out_valid", 32'(out_valid), 32'd0);
    check_eq("mrst_out_data", out_data, 32'h0);
    check_eq("mrst_err_mode", 32'(err_mode), 32'd0);
    check_eq("mrst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    idle(1);
    exp_q.push_back(32'h600D_CAFE);
    send_beat(2'b00, 32'h600D_CAFE);
    check_eq("mrst_next_valid", 32'(out_valid), 32'd1);
    drain();
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
